// File: rtl/cpu_multicycle_p.sv
// rtl/cpu_multicycle_p.sv - parametrised multi-cycle load/store CPU core with two-word ops, HALT and single-step
module cpu_multicycle_p #(
   parameter int BW = 16,
   parameter int AW = 9,
   parameter int NREG = 4,
   parameter logic [AW-1:0] RST_PC = '0
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [BW-1:0] din,
   output logic          mw,
   output logic [AW-1:0] addr,
   output logic [BW-1:0] dout,
   input  logic          step_mode,
   input  logic          step,
   output logic [BW-1:0] r0,
   output logic [BW-1:0] r1,
   output logic [AW-1:0] pc,
   output logic          halted
);
   localparam int RW = $clog2(NREG);
   localparam int XW = BW + 2 * RW;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_FWAIT  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_OWAIT  = 4'd3;
   localparam logic [3:0] S_OPND   = 4'd4;
   localparam logic [3:0] S_EXEC   = 4'd5;
   localparam logic [3:0] S_MWAIT  = 4'd6;
   localparam logic [3:0] S_MREAD  = 4'd7;
   localparam logic [3:0] S_HALT   = 4'd8;

   logic [3:0]    state;
   logic [BW-1:0] ir;
   logic [BW-1:0] opnd;
   logic [BW-1:0] regs [NREG];
   logic [AW-1:0] pc_q;
   logic [XW-1:0] ir_ext;
   logic [3:0]    op;
   logic [RW-1:0] rd;
   logic [RW-1:0] rs;
   logic [BW-1:0] rd_val;
   logic [BW-1:0] rs_val;
   logic [BW-1:0] alu;
   logic [AW-1:0] pc_p1;
   logic [AW-1:0] pc_p2;

   function automatic logic is_two_word(input logic [3:0] o);
      return (o == 4'h1) || (o == 4'h2) || (o == 4'h3) ||
             (o == 4'hB) || (o == 4'hC) || (o == 4'hD);
   endfunction

   // Narrow words cannot hold both register fields; missing low bits read as 0.
   assign ir_ext = {ir, {(2 * RW){1'b0}}};
   assign op     = ir[BW-1 -: 4];
   assign rd     = ir_ext[XW-5 -: RW];
   assign rs     = ir_ext[XW-5-RW -: RW];
   assign rd_val = regs[rd];
   assign rs_val = regs[rs];
   assign pc_p1  = pc_q + AW'(1);
   assign pc_p2  = pc_q + AW'(2);

   assign r0 = regs[0];
   assign r1 = regs[1];
   assign pc = pc_q;

   always_comb begin
      alu = rd_val;
      case (op)
         4'h4:    alu = rs_val;
         4'h5:    alu = rd_val + rs_val;
         4'h6:    alu = rd_val - rs_val;
         4'h7:    alu = rd_val & rs_val;
         4'h8:    alu = rd_val | rs_val;
         4'h9:    alu = rd_val ^ rs_val;
         4'hA:    alu = {rd_val[BW-2:0], 1'b0};
         default: alu = rd_val;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= S_FETCH;
         pc_q   <= RST_PC;
         ir     <= '0;
         opnd   <= '0;
         addr   <= '0;
         dout   <= '0;
         mw     <= 1'b0;
         halted <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         // Write enable lives for exactly the cycle after the store's EXEC.
         mw <= 1'b0;
         case (state)
            S_FETCH: begin
               addr <= pc_q;
               if (!step_mode || step) state <= S_FWAIT;
            end
            S_FWAIT: state <= S_DECODE;
            S_DECODE: begin
               ir <= din;
               if (is_two_word(din[BW-1 -: 4])) begin
                  addr  <= pc_p1;
                  state <= S_OWAIT;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_OWAIT: state <= S_OPND;
            S_OPND: begin
               opnd  <= din;
               state <= S_EXEC;
            end
            S_EXEC: begin
               state <= S_FETCH;
               case (op)
                  4'h1: begin
                     regs[rd] <= opnd;
                     pc_q     <= pc_p2;
                  end
                  4'h2: begin
                     addr  <= opnd[AW-1:0];
                     pc_q  <= pc_p2;
                     state <= S_MWAIT;
                  end
                  4'h3: begin
                     addr <= opnd[AW-1:0];
                     dout <= rs_val;
                     mw   <= 1'b1;
                     pc_q <= pc_p2;
                  end
                  4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                     regs[rd] <= alu;
                     pc_q     <= pc_p1;
                  end
                  4'hB: pc_q <= opnd[AW-1:0];
                  4'hC: pc_q <= (rd_val == '0) ? opnd[AW-1:0] : pc_p2;
                  4'hD: pc_q <= (rd_val != '0) ? opnd[AW-1:0] : pc_p2;
                  4'hF: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  default: pc_q <= pc_p1;
               endcase
            end
            S_MWAIT: state <= S_MREAD;
            S_MREAD: begin
               regs[rd] <= din;
               state    <= S_FETCH;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_multicycle_p.sv
// tb/tb_cpu_multicycle_p.sv - bench for cpu_multicycle_p: ISA-level model with latency table plus directed programs
module tb_cpu_multicycle_p;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] din;
   logic        mw;
   logic [8:0]  addr;
   logic [15:0] dout;
   logic        step_mode = 1'b0;
   logic        step = 1'b0;
   logic [15:0] r0;
   logic [15:0] r1;
   logic [8:0]  pc;
   logic        halted;

   logic        rstn8 = 1'b0;
   logic [7:0]  din8;
   logic        mw8;
   logic [7:0]  addr8;
   logic [7:0]  dout8;
   logic        step_mode8 = 1'b0;
   logic        step8 = 1'b0;
   logic [7:0]  r0_8;
   logic [7:0]  r1_8;
   logic [7:0]  pc8;
   logic        halted8;

   int n_vec = 0;
   int n_err = 0;
   int mw_pulses = 0;
   int mw8_pulses = 0;
   logic [8:0]  last_a;
   logic [15:0] last_d;

   logic [15:0] mem  [512];
   logic [7:0]  mem8 [256];

   always #5 clk = ~clk;

   cpu_multicycle_p u_dut (
      .clk(clk), .rstn(rstn), .din(din), .mw(mw), .addr(addr), .dout(dout),
      .step_mode(step_mode), .step(step), .r0(r0), .r1(r1), .pc(pc), .halted(halted)
   );

   cpu_multicycle_p #(.BW(8), .AW(8), .NREG(8)) u_dut8 (
      .clk(clk), .rstn(rstn8), .din(din8), .mw(mw8), .addr(addr8), .dout(dout8),
      .step_mode(step_mode8), .step(step8), .r0(r0_8), .r1(r1_8), .pc(pc8), .halted(halted8)
   );

   always @(posedge clk) begin
      din <= mem[addr];
      if (mw) mem[addr] = dout;
      din8 <= mem8[addr8];
      if (mw8) mem8[addr8] = dout8;
   end

   always @(negedge clk) begin
      if (mw) begin
         mw_pulses++;
         last_a = addr;
         last_d = dout;
      end
      if (mw8) mw8_pulses++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Architectural model: whole instruction planned at its FETCH, committed after its latency.
   logic [15:0] mm [512];
   logic [8:0]  m_pc, n_pc, st_a, n_st_a;
   logic [15:0] m_r [4];
   logic [15:0] n_r [4];
   logic [15:0] st_d, n_st_d;
   logic        m_halted, n_halt, st_pend, n_st;
   int          cnt, lat;

   task automatic m_reset();
      m_pc = 9'd0;
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
      m_halted = 1'b0;
      st_pend = 1'b0;
      cnt = 0;
   endtask

   task automatic plan();
      logic [15:0] w, w2, a, b;
      logic [3:0]  o;
      logic [1:0]  d, s;
      w  = mm[m_pc];
      w2 = mm[m_pc + 9'd1];
      o = w[15:12]; d = w[11:10]; s = w[9:8];
      a = m_r[d]; b = m_r[s];
      n_r = m_r; n_halt = 1'b0; n_st = 1'b0; n_st_a = '0; n_st_d = '0;
      n_pc = m_pc + 9'd1;
      lat = 4;
      case (o)
         4'h1: begin n_r[d] = w2; n_pc = m_pc + 9'd2; lat = 6; end
         4'h2: begin n_r[d] = mm[w2[8:0]]; n_pc = m_pc + 9'd2; lat = 8; end
         4'h3: begin n_st = 1'b1; n_st_a = w2[8:0]; n_st_d = b; n_pc = m_pc + 9'd2; lat = 6; end
         4'h4: n_r[d] = b;
         4'h5: n_r[d] = a + b;
         4'h6: n_r[d] = a - b;
         4'h7: n_r[d] = a & b;
         4'h8: n_r[d] = a | b;
         4'h9: n_r[d] = a ^ b;
         4'hA: n_r[d] = a << 1;
         4'hB: begin n_pc = w2[8:0]; lat = 6; end
         4'hC: begin n_pc = (a == 0) ? w2[8:0] : m_pc + 9'd2; lat = 6; end
         4'hD: begin n_pc = (a != 0) ? w2[8:0] : m_pc + 9'd2; lat = 6; end
         4'hF: begin n_pc = m_pc; n_halt = 1'b1; end
         default: ;
      endcase
   endtask

   task automatic commit();
      m_r = n_r;
      m_pc = n_pc;
      m_halted = n_halt;
      if (n_st) begin
         mm[n_st_a] = n_st_d;
         st_pend = 1'b1;
         st_a = n_st_a;
         st_d = n_st_d;
      end
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         m_reset();
         chk("rst_pc", pc, 0);
         chk("rst_r0", r0, 0);
         chk("rst_r1", r1, 0);
         chk("rst_mw", mw, 0);
         chk("rst_addr", addr, 0);
         chk("rst_dout", dout, 0);
         chk("rst_halted", halted, 0);
      end else if (m_halted) begin
         chk("halt_flag", halted, 1);
         chk("halt_pc", pc, m_pc);
         chk("halt_r0", r0, m_r[0]);
         chk("halt_r1", r1, m_r[1]);
         chk("halt_mw", mw, 0);
      end else if (cnt == 0) begin
         chk("bnd_pc", pc, m_pc);
         chk("bnd_r0", r0, m_r[0]);
         chk("bnd_r1", r1, m_r[1]);
         chk("bnd_halted", halted, 0);
         chk("bnd_mw", mw, st_pend);
         if (st_pend) begin
            chk("st_addr", addr, st_a);
            chk("st_dout", dout, st_d);
         end
         st_pend = 1'b0;
         if (!step_mode || step) begin
            plan();
            cnt = 1;
         end
      end else begin
         chk("busy_mw", mw, 0);
         cnt++;
         if (cnt == lat) begin
            commit();
            cnt = 0;
         end
      end
   end

   task automatic put(input int a, input logic [15:0] w);
      mem[a] = w;
      mm[a] = w;
   endtask

   task automatic start_test();
      @(posedge clk);
      #2 rstn = 1'b0;
      for (int i = 0; i < 512; i++) begin
         mem[i] = '0;
         mm[i] = '0;
      end
   endtask

   task automatic release_rst();
      @(posedge clk);
      #2 rstn = 1'b1;
   endtask

   task automatic wait_halt(input string nm, input int budget, input int exp_cycles);
      int n;
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (halted) begin
            n = i;
            break;
         end
      end
      chk(nm, n, exp_cycles);
   endtask

   initial begin
      int mp0;
      for (int i = 0; i < 256; i++) mem8[i] = '0;

      // Reset / LDI
      start_test();
      put(0, 16'h1000); put(1, 16'h1234); put(2, 16'h1400); put(3, 16'h00FF); put(4, 16'hF000);
      release_rst();
      wait_halt("ldi_halt_cycles", 100, 16);
      chk("ldi_r0", r0, 16'h1234);
      chk("ldi_r1", r1, 16'h00FF);
      chk("ldi_pc", pc, 4);

      // ALU wrap
      start_test();
      mp0 = mw_pulses;
      put(0, 16'h1000); put(1, 16'hFFFF); put(2, 16'h1400); put(3, 16'h0002);
      put(4, 16'h5100); put(5, 16'h6400); put(6, 16'hA400); put(7, 16'hF000);
      release_rst();
      wait_halt("alu_halt_cycles", 100, 28);
      chk("alu_r0", r0, 16'h0001);
      chk("alu_r1", r1, 16'h0002);
      chk("alu_no_mw", mw_pulses, mp0);

      // Logic ops, NOP, reserved opcode, JZ both ways
      start_test();
      put(0, 16'h1000); put(1, 16'h0F0F); put(2, 16'h1400); put(3, 16'h00FF);
      put(4, 16'h7100); put(5, 16'h8400); put(6, 16'h9100); put(7, 16'h0000);
      put(8, 16'hE000); put(9, 16'hC000); put(10, 16'h0000); put(11, 16'h1000);
      put(12, 16'h0000); put(13, 16'hC000); put(14, 16'h0011); put(15, 16'h1400);
      put(16, 16'hDEAD); put(17, 16'hF000);
      release_rst();
      wait_halt("misc_halt_cycles", 200, 54);
      chk("misc_r0", r0, 16'h0000);
      chk("misc_r1", r1, 16'h00FF);
      chk("misc_pc", pc, 17);

      // PC wrap through a two-word instruction at the top of memory
      start_test();
      put(0, 16'hC000); put(1, 16'h01FE); put(2, 16'hF000); put(510, 16'h0000); put(511, 16'h1400);
      release_rst();
      wait_halt("wrap_halt_cycles", 100, 24);
      chk("wrap_r1", r1, 16'hC000);
      chk("wrap_pc", pc, 2);

      // Memory round trip
      start_test();
      mp0 = mw_pulses;
      put(0, 16'h1400); put(1, 16'hBEEF); put(2, 16'h3100); put(3, 16'h01F0);
      put(4, 16'h2000); put(5, 16'h01F0); put(6, 16'hF000);
      release_rst();
      wait_halt("mem_halt_cycles", 100, 24);
      chk("mem_r0", r0, 16'hBEEF);
      chk("mem_pulses", mw_pulses - mp0, 1);
      chk("mem_st_addr", last_a, 9'h1F0);
      chk("mem_st_dout", last_d, 16'hBEEF);
      chk("mem_cell", mem[9'h1F0], 16'hBEEF);

      // Branch loop, body runs three times
      start_test();
      put(0, 16'h1000); put(1, 16'h0003); put(2, 16'h1400); put(3, 16'h0001);
      put(4, 16'h6100); put(5, 16'hD000); put(6, 16'h0002); put(7, 16'hF000);
      release_rst();
      wait_halt("loop_halt_cycles", 200, 58);
      chk("loop_r0", r0, 16'h0000);
      chk("loop_pc", pc, 7);

      // Step mode
      start_test();
      step_mode = 1'b1;
      put(0, 16'h1000); put(1, 16'h0042); put(2, 16'h4400); put(3, 16'hF000);
      release_rst();
      repeat (50) @(posedge clk);
      #1;
      chk("step_idle_pc", pc, 0);
      chk("step_idle_r0", r0, 0);
      #1 step = 1'b1;
      @(posedge clk);
      #2 step = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("step_one_pc", pc, 2);
      chk("step_one_r0", r0, 16'h0042);
      #1 step = 1'b1;
      @(posedge clk);
      #2 step = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 step = 1'b1;
      @(posedge clk);
      #2 step = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("step_two_pc", pc, 3);
      chk("step_two_r1", r1, 16'h0042);
      #1 step_mode = 1'b0;
      wait_halt("step_halt_cycles", 20, 4);
      #1 step_mode = 1'b1;
      step = 1'b1;
      repeat (3) @(posedge clk);
      #2 step = 1'b0;
      step_mode = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("halt_absorb_flag", halted, 1);
      chk("halt_absorb_pc", pc, 3);

      // Reset in ST's EXEC cycle
      start_test();
      mp0 = mw_pulses;
      put(0, 16'h1400); put(1, 16'hBEEF); put(2, 16'h3100); put(3, 16'h01F0); put(4, 16'hF000);
      release_rst();
      repeat (11) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("abort_mw", mw, 0);
      chk("abort_addr", addr, 0);
      chk("abort_dout", dout, 0);
      chk("abort_pc", pc, 0);
      chk("abort_r1", r1, 0);
      chk("abort_halted", halted, 0);
      repeat (3) @(posedge clk);
      chk("abort_cell", mem[9'h1F0], 16'h0000);
      chk("abort_pulses", mw_pulses - mp0, 0);
      #2 rstn = 1'b1;
      wait_halt("abort_rerun_cycles", 100, 16);
      chk("abort_rerun_cell", mem[9'h1F0], 16'hBEEF);
      chk("abort_rerun_pulses", mw_pulses - mp0, 1);
      chk("abort_rerun_pc", pc, 4);

      // Same abort on the narrow BW=8/AW=8/NREG=8 build
      mem8[0] = 8'h10; mem8[1] = 8'h5A; mem8[2] = 8'h30; mem8[3] = 8'h80; mem8[4] = 8'hF0;
      @(posedge clk);
      #2 rstn8 = 1'b1;
      repeat (11) @(posedge clk);
      #2 rstn8 = 1'b0;
      #1;
      chk("n8_abort_mw", mw8, 0);
      chk("n8_abort_addr", addr8, 0);
      chk("n8_abort_dout", dout8, 0);
      chk("n8_abort_pc", pc8, 0);
      chk("n8_abort_r0", r0_8, 0);
      chk("n8_abort_r1", r1_8, 0);
      chk("n8_abort_halted", halted8, 0);
      repeat (3) @(posedge clk);
      chk("n8_abort_cell", mem8[8'h80], 8'h00);
      chk("n8_abort_pulses", mw8_pulses, 0);
      #2 rstn8 = 1'b1;
      begin
         int n;
         n = -1;
         for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (halted8) begin
               n = i;
               break;
            end
         end
         chk("n8_halt_cycles", n, 16);
      end
      chk("n8_cell", mem8[8'h80], 8'h5A);
      chk("n8_pulses", mw8_pulses, 1);
      chk("n8_pc", pc8, 4);
      chk("n8_r0", r0_8, 8'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
